lsnn_spike_window_decoder: RTL and testbench
============================================

Name: lsnn_spike_window_decoder

Overview:
Downstream consumer of the LSNN neuron. Samples the neuron's 1-bit spike output and 8-bit adaptive threshold every clock, and accumulates statistics over fixed windows of WINDOW_LEN cycles. Per window it produces a spike count (rate code), the last inter-spike interval and the peak threshold. Results are offered on a valid/ready port with a one-entry holding register, so a slow reader or host readout can consume decoded activity.

Parameters:
WINDOW_LEN, 64, window length in clock cycles; legal range 2..65535.
CNT_W, 8, spike-count width; count saturates at 2^CNT_W-1.
ISI_W, 8, inter-spike-interval width; interval saturates at 2^ISI_W-1.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  reset, synchronous, active-high (1 = reset), sampled on clk rising edge.
en  input  1  start/continue windowing; sampled only in IDLE and at window end.
spike_in  input  1  neuron spike (bit 0 of neuron spike output).
thresh_in  input  8  neuron threshold, unsigned.
rate_out  output  CNT_W  spikes in last delivered window.
isi_out  output  ISI_W  last inter-spike interval in that window; 0 if fewer than 2 spikes.
thr_max_out  output  8  maximum thresh_in sampled in that window.
res_valid  output  1  result registers hold an unconsumed result.
res_ready  input  1  consumer accepts result when res_valid & res_ready.
overrun  output  1  sticky: a window result was dropped.
busy  output  1  1 while in RUN.

Behaviour:
- Reset (rst_n=1 at an edge): state IDLE. win_cnt, spike_cnt, isi_cnt, thr_acc and seen_spike are cleared. All outputs are 0. Reset overrides everything, including mid-window: the partial window is discarded and any pending result is lost.
- FSM has two states, IDLE and RUN.
  - IDLE -> RUN on the edge where en=1. Accumulators are cleared on that edge.
  - The first sampled cycle is the first RUN cycle.
  - No sampling takes place in IDLE.
- Every RUN cycle:
  - win_cnt += 1.
  - spike_cnt += spike_in, saturating.
  - thr_acc = max(thr_acc, thresh_in).
  - isi_cnt increments, saturating at 2^ISI_W-1.
- On a RUN cycle with spike_in=1:
  - If seen_spike, isi_last <= min(isi_cnt+1, 2^ISI_W-1).
  - isi_cnt <= 0 and seen_spike <= 1.
  - Spikes on consecutive cycles give ISI 1.
- Window end is the RUN cycle with win_cnt == WINDOW_LEN-1. That cycle's sample is included in the result. On that edge:
  - If res_valid=0 or res_ready=1: rate_out, isi_out and thr_max_out load the final values. isi_out is 0 if fewer than 2 spikes were seen. res_valid <= 1.
  - Otherwise the new result is dropped, overrun <= 1, and the old outputs are held unchanged.
  - Accumulators, win_cnt and seen_spike are cleared.
  - en=1 -> stay in RUN; the next window starts the next cycle with no gap. en=0 -> IDLE.
- en deasserted mid-window has no effect. The window always completes.
- Handshake:
  - Outputs are stable while res_valid & !res_ready.
  - Transfer occurs on an edge with res_valid & res_ready. res_valid falls next cycle unless a new result loads on that same edge, in which case it stays 1 with the new data.
  - No combinational path from res_ready to any output.
- overrun is sticky until reset.
- busy = (state == RUN). Latency from window end to res_valid is 1 cycle.

Decomposition:
- Package lsnn_pkg holds:
  - THR_W = 8.
  - Default CNT_W and ISI_W.
  - typedef enum {IDLE, RUN} for the decoder state.
- One natural sub-module: lsnn_sat_inc, a parameterised saturating incrementer (width, increment enable, clear). It is instanced for spike_cnt and isi_cnt.
- win_cnt width is clog2(WINDOW_LEN) in the top module.

Test Plan (WINDOW_LEN=8 unless noted):
1. Reset: hold rst_n=1 for 2 cycles with en=1 and spikes active -> all outputs 0, busy=0. Then assert rst_n for 1 cycle mid-window -> partial window discarded, no res_valid.
2. Full activity: en=1, res_ready=1, spike_in=1 for all 8 cycles -> one cycle after window end: rate_out=8, isi_out=1, res_valid pulses for exactly 1 cycle.
3. Sparse spikes in one window:
   - Spikes at window cycles 1 and 5 -> rate_out=2, isi_out=4.
   - A single spike in the next window -> rate_out=1, isi_out=0.
   - thresh_in 8,10,14,12,8,8,8,8 -> thr_max_out=14.
4. Backpressure: res_ready=0 across two window ends -> first result held unchanged, overrun=1 after the second window end. Then raise res_ready -> first result is transferred, and res_valid drops the next cycle.
5. Saturation: CNT_W=3, ISI_W=3, WINDOW_LEN=16.
   - All cycles spiking -> rate_out=7.
   - Spikes only at cycles 0 and 12 -> isi_out=7.
6. Control: en=1 for 1 cycle only -> exactly one window is completed, then IDLE and busy=0. en held high -> back-to-back windows, with res_valid every 8 cycles when res_ready=1.

Source files
------------

// File: rtl/lsnn_spike_window_decoder_pkg.sv
// Shared definitions for the LSNN spike window decoder.
//   THR_W      : width of the neuron threshold samples
//   CNT_W_DEF  : default spike-count width
//   ISI_W_DEF  : default inter-spike-interval width
//   dec_state_e: decoder FSM state (IDLE / RUN)
package lsnn_spike_window_decoder_pkg;

    localparam int THR_W     = 8;
    localparam int CNT_W_DEF = 8;
    localparam int ISI_W_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dec_state_e;

endpackage

// File: rtl/lsnn_spike_window_decoder_if.sv
// Result port of the LSNN spike window decoder.
//
// Handshake: res_valid is raised by the master when the result fields hold
// an unconsumed window result; the fields and res_valid stay stable until a
// rising clk edge where res_valid & res_ready are both 1, which transfers
// the result. res_ready never affects any master output combinationally.
//
//   rate_out    : spikes counted in the delivered window (CNT_W)
//   isi_out     : last inter-spike interval in that window, 0 if < 2 spikes
//   thr_max_out : largest threshold sampled in that window
//   res_valid   : result fields hold an unconsumed result
//   res_ready   : consumer accepts the result
interface lsnn_spike_window_decoder_if
    import lsnn_spike_window_decoder_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int ISI_W = ISI_W_DEF
) ();

    logic [CNT_W-1:0] rate_out;
    logic [ISI_W-1:0] isi_out;
    logic [THR_W-1:0] thr_max_out;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output rate_out,
        output isi_out,
        output thr_max_out,
        output res_valid,
        input  res_ready
    );

    modport slave (
        input  rate_out,
        input  isi_out,
        input  thr_max_out,
        input  res_valid,
        output res_ready
    );

endinterface

// File: rtl/lsnn_spike_window_decoder_sat_inc.sv
// Saturating counter used for the spike count and the inter-spike interval.
//   clk     : clock
//   rst_n   : synchronous active-high reset (1 = reset)
//   clr_i   : clear the count on the next edge (wins over increment)
//   inc_i   : increment by one this cycle, sticking at all-ones
//   next_o  : value the count takes on the next edge if not cleared; lets
//             the owner capture the final value on the same edge it clears
module lsnn_spike_window_decoder_sat_inc #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] next_o
);

    logic [W-1:0] cnt_q;

    always_comb begin
        next_o = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            next_o = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= next_o;
        end
    end

endmodule

// File: rtl/lsnn_spike_window_decoder.sv
// Decodes an LSNN neuron's spike train over fixed windows of WINDOW_LEN
// cycles: spike count, last inter-spike interval and peak threshold, offered
// on a valid/ready port with a one-entry holding register.
//   clk         : clock
//   rst_n       : synchronous active-high reset (1 = reset)
//   en          : start/continue windowing (looked at in IDLE and window end)
//   spike_in    : neuron spike
//   thresh_in   : neuron adaptive threshold, unsigned
//   res         : result port (master side of lsnn_spike_window_decoder_if)
//   overrun     : sticky, a finished window result was dropped
//   busy        : 1 while in RUN
//   state_dbg_o : current FSM state
module lsnn_spike_window_decoder
    import lsnn_spike_window_decoder_pkg::*;
#(
    parameter int WINDOW_LEN = 64,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int ISI_W      = ISI_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         spike_in,
    input  logic [THR_W-1:0]             thresh_in,
    lsnn_spike_window_decoder_if.master  res,
    output logic                         overrun,
    output logic                         busy,
    output dec_state_e                   state_dbg_o
);

    localparam int              WIN_W    = $clog2(WINDOW_LEN);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);

    dec_state_e       state_q;
    logic [WIN_W-1:0] win_cnt_q;
    logic [THR_W-1:0] thr_acc_q;
    logic             seen_spike_q;
    logic [ISI_W-1:0] isi_last_q;
    logic             overrun_q;

    logic             run;
    logic             win_end;
    logic             spk;
    logic [CNT_W-1:0] spike_next;
    logic [ISI_W-1:0] isi_next;
    logic [THR_W-1:0] thr_d;
    logic [ISI_W-1:0] isi_last_d;
    logic             can_load;

    assign run     = (state_q == RUN);
    assign win_end = run && (win_cnt_q == WIN_LAST);
    assign spk     = run && spike_in;

    lsnn_spike_window_decoder_sat_inc #(.W(CNT_W)) u_spike_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (!run || win_end),
        .inc_i  (spk),
        .next_o (spike_next)
    );

    // The interval counter restarts on every spike; next_o is the interval
    // ending at this cycle's spike (consecutive spikes give 1).
    lsnn_spike_window_decoder_sat_inc #(.W(ISI_W)) u_isi_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (!run || win_end || spike_in),
        .inc_i  (run),
        .next_o (isi_next)
    );

    always_comb begin
        thr_d = thr_acc_q;
        if (run && (thresh_in > thr_acc_q)) begin
            thr_d = thresh_in;
        end
        // isi_last_q stays 0 until a second spike, which is the "fewer than
        // two spikes" result value; an interval is never 0 otherwise.
        isi_last_d = isi_last_q;
        if (spk && seen_spike_q) begin
            isi_last_d = isi_next;
        end
    end

    // A new result fits if the holder is empty or being emptied this edge.
    assign can_load = !res.res_valid || res.res_ready;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q         <= IDLE;
            win_cnt_q       <= '0;
            thr_acc_q       <= '0;
            seen_spike_q    <= 1'b0;
            isi_last_q      <= '0;
            overrun_q       <= 1'b0;
            res.rate_out    <= '0;
            res.isi_out     <= '0;
            res.thr_max_out <= '0;
            res.res_valid   <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                win_cnt_q    <= '0;
                thr_acc_q    <= '0;
                seen_spike_q <= 1'b0;
                isi_last_q   <= '0;
                if (en) begin
                    state_q <= RUN;
                end
            end else if (win_end) begin
                win_cnt_q    <= '0;
                thr_acc_q    <= '0;
                seen_spike_q <= 1'b0;
                isi_last_q   <= '0;
                if (!en) begin
                    state_q <= IDLE;
                end
            end else begin
                win_cnt_q    <= win_cnt_q + WIN_W'(1);
                thr_acc_q    <= thr_d;
                seen_spike_q <= seen_spike_q | spike_in;
                isi_last_q   <= isi_last_d;
            end

            if (win_end && can_load) begin
                res.rate_out    <= spike_next;
                res.isi_out     <= isi_last_d;
                res.thr_max_out <= thr_d;
                res.res_valid   <= 1'b1;
            end else begin
                if (win_end) begin
                    overrun_q <= 1'b1;
                end
                if (res.res_valid && res.res_ready) begin
                    res.res_valid <= 1'b0;
                end
            end
        end
    end

    assign overrun     = overrun_q;
    assign busy        = run;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_lsnn_spike_window_decoder.sv
// Testbench: two decoders share one stimulus stream; instance 0 uses 8-cycle
// windows with 8-bit fields, instance 1 uses 16-cycle windows with 3-bit
// count/interval fields so saturation is reachable.
module tb_lsnn_spike_window_decoder;
    import lsnn_spike_window_decoder_pkg::*;

    localparam int WL   [2] = '{8, 16};
    localparam int CMAX [2] = '{255, 7};
    localparam int IMAX [2] = '{255, 7};

    // ---------------- clock / reset / DUTs ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       spike_in = 1'b0;
    logic [7:0] thresh_in = '0;
    logic       ready = 1'b0;
    logic       mon_on = 1'b0;

    always #5 clk = ~clk;

    lsnn_spike_window_decoder_if #(.CNT_W(8), .ISI_W(8)) ifa ();
    lsnn_spike_window_decoder_if #(.CNT_W(3), .ISI_W(3)) ifb ();
    assign ifa.res_ready = ready;
    assign ifb.res_ready = ready;

    logic       ovr_a, ovr_b, busy_a, busy_b;
    dec_state_e st_a, st_b;

    lsnn_spike_window_decoder #(.WINDOW_LEN(8), .CNT_W(8), .ISI_W(8)) dut_a (
        .clk(clk), .rst_n(rst), .en(en), .spike_in(spike_in), .thresh_in(thresh_in),
        .res(ifa), .overrun(ovr_a), .busy(busy_a), .state_dbg_o(st_a)
    );

    lsnn_spike_window_decoder #(.WINDOW_LEN(16), .CNT_W(3), .ISI_W(3)) dut_b (
        .clk(clk), .rst_n(rst), .en(en), .spike_in(spike_in), .thresh_in(thresh_in),
        .res(ifb), .overrun(ovr_b), .busy(busy_b), .state_dbg_o(st_b)
    );

    logic [23:0] data [2];
    logic        valid [2];
    logic        ovr [2];
    logic        busy [2];
    logic        st_run [2];
    always_comb begin
        data[0]   = {ifa.rate_out, ifa.isi_out, ifa.thr_max_out};
        data[1]   = {5'b0, ifb.rate_out, 5'b0, ifb.isi_out, ifb.thr_max_out};
        valid[0]  = ifa.res_valid;
        valid[1]  = ifb.res_valid;
        ovr[0]    = ovr_a;
        ovr[1]    = ovr_b;
        busy[0]   = busy_a;
        busy[1]   = busy_b;
        st_run[0] = (st_a == RUN);
        st_run[1] = (st_b == RUN);
    end

    // ---------------- scoreboard state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [23:0] exp_a[$];
    logic [23:0] exp_b[$];

    task automatic chk(input string name, input int k, input logic [23:0] act, input logic [23:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] t=%0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Works from the window rules directly: count spikes, remember the sample
    // indices of the last two spikes, keep the peak threshold. m_pend tracks
    // whether the consumer-visible holder is occupied.
    logic m_run [2];
    logic m_pend [2];
    logic m_ovr [2];
    logic m_zero [2];
    int   m_n [2];
    int   m_cnt [2];
    int   m_last [2];
    int   m_prev [2];
    int   m_thr [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_run[k]  = 1'b0;
                m_pend[k] = 1'b0;
                m_ovr[k]  = 1'b0;
                m_zero[k] = 1'b1;
                if (k == 0) exp_a.delete(); else exp_b.delete();
            end else if (!m_run[k]) begin
                if (m_pend[k] && ready) m_pend[k] = 1'b0;
                if (en) begin
                    m_run[k] = 1'b1;
                    m_n[k] = 0; m_cnt[k] = 0; m_last[k] = -1; m_prev[k] = -1; m_thr[k] = 0;
                end
            end else begin
                if (spike_in) begin
                    m_cnt[k]++;
                    m_prev[k] = m_last[k];
                    m_last[k] = m_n[k];
                end
                if (int'(thresh_in) > m_thr[k]) m_thr[k] = int'(thresh_in);
                m_n[k]++;
                if (m_n[k] == WL[k]) begin
                    int rate, isi;
                    rate = (m_cnt[k] > CMAX[k]) ? CMAX[k] : m_cnt[k];
                    isi  = 0;
                    if (m_prev[k] >= 0) begin
                        isi = m_last[k] - m_prev[k];
                        if (isi > IMAX[k]) isi = IMAX[k];
                    end
                    if (!m_pend[k] || ready) begin
                        if (k == 0) exp_a.push_back({8'(rate), 8'(isi), 8'(m_thr[k])});
                        else        exp_b.push_back({8'(rate), 8'(isi), 8'(m_thr[k])});
                        m_pend[k] = 1'b1;
                        m_zero[k] = 1'b0;
                    end else begin
                        m_ovr[k] = 1'b1;
                    end
                    m_run[k] = en;
                    m_n[k] = 0; m_cnt[k] = 0; m_last[k] = -1; m_prev[k] = -1; m_thr[k] = 0;
                end else if (m_pend[k] && ready) begin
                    m_pend[k] = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_on) begin
            for (int k = 0; k < 2; k++) begin
                int qs;
                chk("res_valid", k, 24'(valid[k]), 24'(m_pend[k]));
                chk("busy", k, 24'(busy[k]), 24'(m_run[k]));
                chk("state_dbg", k, 24'(st_run[k]), 24'(m_run[k]));
                chk("overrun", k, 24'(ovr[k]), 24'(m_ovr[k]));
                qs = (k == 0) ? exp_a.size() : exp_b.size();
                if (valid[k]) begin
                    if (qs == 0) begin
                        chk("result_unexpected", k, data[k], 24'hxxxxxx);
                    end else begin
                        chk("result", k, data[k], (k == 0) ? exp_a[0] : exp_b[0]);
                        if (ready) begin
                            if (k == 0) void'(exp_a.pop_front()); else void'(exp_b.pop_front());
                        end
                    end
                end else if (m_zero[k]) begin
                    chk("zero_after_reset", k, data[k], 24'h0);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic e, input logic s, input logic [7:0] t, input logic r);
        en = e;
        spike_in = s;
        thresh_in = t;
        ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) cyc(1'b0, 1'b0, 8'($urandom_range(0, 255)), 1'b1);
    endtask

    logic [7:0] thr_tab [8] = '{8'd8, 8'd10, 8'd14, 8'd12, 8'd8, 8'd8, 8'd8, 8'd8};

    initial begin
        // reset held two cycles with activity on the inputs
        rst = 1'b1;
        cyc(1'b1, 1'b1, 8'h40, 1'b1);
        mon_on = 1'b1;
        cyc(1'b1, 1'b1, 8'h50, 1'b1);
        rst = 1'b0;
        // start a window, then reset in the middle of it
        cyc(1'b1, 1'b1, 8'h20, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 8'h33, 1'b1);
        rst = 1'b0;
        gap(20);

        // full activity for one window
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
        gap(20);

        // sparse spikes with a threshold profile, then a single-spike window
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1, (i == 1) || (i == 5), thr_tab[i], 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, (i == 3), 8'd5, 1'b1);
        gap(20);

        // backpressure across two window ends, then release
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++)
            cyc(i < 15, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        gap(20);

        // saturation on the 16-cycle / 3-bit instance: spikes at 0 and 12
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) cyc(1'b0, (i == 0) || (i == 12), 8'($urandom_range(0, 255)), 1'b1);
        gap(24);
        // every cycle spiking
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
        gap(24);

        // en held high: back-to-back windows
        for (int i = 0; i < 48; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1);
        gap(24);

        // random traffic with occasional resets and random backpressure
        repeat (800) begin
            rst = ($urandom_range(0, 149) == 0);
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
        end
        rst = 1'b0;
        gap(40);

        chk("drain", 0, 24'(exp_a.size()), 24'h0);
        chk("drain", 1, 24'(exp_b.size()), 24'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
